// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - A2D conversion scheduler: tick generator, masked channel sweep, result store
// Sweeps the masked channels in ascending order, one A2D start/complete handshake per channel.
module conv_sched #(
    parameter int                NUM_CH  = 3,
    parameter int                CH_W    = 3,
    parameter int                DATA_W  = 12,
    parameter int                CNT_W   = 19,
    parameter int                TO_CYC  = 1024,
    parameter int                BATT_CH = 2,
    parameter logic [DATA_W-1:0] BATT_TH = 12'h800
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     mode,
    input  logic                     trig,
    input  logic [CNT_W-1:0]         period,
    input  logic [NUM_CH-1:0]        ch_mask,
    output logic                     strt_cnv,
    output logic [CH_W-1:0]          chnnl,
    input  logic                     cnv_cmplt,
    input  logic [DATA_W-1:0]        res,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_vld,
    output logic [NUM_CH-1:0]        upd,
    output logic                     sweep_done,
    output logic                     nxt,
    output logic                     ovrrun,
    output logic                     batt_low,
    output logic                     timeout_err
);

    localparam int WC_W = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, CONV} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [WC_W-1:0]    wcnt_q, wcnt_d;
    logic [DATA_W-1:0]  data_q [NUM_CH];
    logic [DATA_W-1:0]  data_d [NUM_CH];
    logic [NUM_CH-1:0]  vld_q, vld_d;
    logic [NUM_CH-1:0]  upd_q, upd_d;
    logic               done_q, done_d;
    logic               batt_q, batt_d;
    logic               to_q, to_d;

    logic               req;
    logic               first_hit, next_hit;
    logic [CH_W-1:0]    first_ch, next_ch;

    always_comb begin
        nxt    = en && (cnt_q == period);
        cnt_d  = (!en || nxt) ? '0 : cnt_q + CNT_W'(1);
        req    = en && (mode ? trig : nxt);
        ovrrun = req && (state_q != IDLE);

        // Descending scan leaves the lowest qualifying index selected.
        first_hit = 1'b0;
        first_ch  = '0;
        next_hit  = 1'b0;
        next_ch   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_hit = 1'b1;
                first_ch  = CH_W'(i);
            end
            if (mask_q[i] && (CH_W'(i) > ch_q)) begin
                next_hit = 1'b1;
                next_ch  = CH_W'(i);
            end
        end

        state_d = state_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;
        vld_d   = vld_q;
        upd_d   = '0;
        done_d  = 1'b0;
        batt_d  = batt_q;
        to_d    = to_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    mask_d = ch_mask;
                    ch_d   = first_ch;
                    if (first_hit) state_d = LAUNCH;
                    else           done_d  = 1'b1;
                end
            end
            LAUNCH: begin
                wcnt_d  = WC_W'(1);
                state_d = CONV;
            end
            CONV: begin
                if (cnv_cmplt) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (CH_W'(i) == ch_q) begin
                            data_d[i] = res;
                            upd_d[i]  = 1'b1;
                            vld_d[i]  = 1'b1;
                        end
                    end
                    if (ch_q == CH_W'(BATT_CH)) batt_d = (res < BATT_TH);
                    // A dropped enable lets this conversion land but ends the sweep silently.
                    if (en && next_hit) begin
                        ch_d    = next_ch;
                        state_d = LAUNCH;
                    end else begin
                        state_d = IDLE;
                        done_d  = en;
                    end
                end else if (wcnt_q == WC_W'(TO_CYC - 1)) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + WC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            ch_q    <= '0;
            wcnt_q  <= '0;
            data_q  <= '{default: '0};
            vld_q   <= '0;
            upd_q   <= '0;
            done_q  <= 1'b0;
            batt_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            wcnt_q  <= wcnt_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            upd_q   <= upd_d;
            done_q  <= done_d;
            batt_q  <= batt_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) ch_data[i*DATA_W +: DATA_W] = data_q[i];
    end

    assign strt_cnv    = (state_q == LAUNCH);
    assign chnnl       = ch_q;
    assign ch_vld      = vld_q;
    assign upd         = upd_q;
    assign sweep_done  = done_q;
    assign batt_low    = batt_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - directed self-checking bench for conv_sched
module tb_conv_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, mode = 1'b0, trig = 1'b0;
    logic [18:0] period = 19'd100;
    logic [2:0]  ch_mask = 3'b000;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt = 1'b0;
    logic [11:0] res = '0;
    logic [35:0] ch_data;
    logic [2:0]  ch_vld, upd;
    logic        sweep_done, nxt, ovrrun, batt_low, timeout_err;

    conv_sched dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .trig(trig), .period(period),
        .ch_mask(ch_mask), .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt),
        .res(res), .ch_data(ch_data), .ch_vld(ch_vld), .upd(upd), .sweep_done(sweep_done),
        .nxt(nxt), .ovrrun(ovrrun), .batt_low(batt_low), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A2D model: completes a fixed latency after strt_cnv; keeps running across rst.
    int          lat = 2;
    logic        a2d_on = 1'b1;
    logic        pend = 1'b0;
    int          cd = 0;
    logic [2:0]  pch = '0;
    logic [11:0] res_tab [3];

    always @(negedge clk) begin
        cnv_cmplt = 1'b0;
        if (pend) begin
            if (cd == 0) begin
                cnv_cmplt = 1'b1;
                res       = res_tab[pch];
                pend      = 1'b0;
            end else begin
                cd--;
            end
        end
        if (strt_cnv && a2d_on && !pend) begin
            pend = 1'b1;
            pch  = chnnl;
            cd   = lat - 1;
        end
    end

    int         cyc = 0;
    logic [2:0] strt_log [$];
    int         nxt_log [$];
    int         ovr_cnt, ovr_bad, done_cnt, upd_cnt, upd_bad, strt_time, to_time;

    always @(negedge clk) begin
        cyc++;
        if (strt_cnv) begin
            strt_log.push_back(chnnl);
            if (strt_log.size() == 1) strt_time = cyc;
        end
        if (nxt) nxt_log.push_back(cyc);
        if (ovrrun) begin
            ovr_cnt++;
            if (!nxt) ovr_bad++;
        end
        if (sweep_done) done_cnt++;
        if (upd != 3'b000) begin
            upd_cnt++;
            if ((upd & (upd - 3'd1)) != 3'b000) upd_bad++;
        end
        if (timeout_err && to_time < 0) to_time = cyc;
    end

    task automatic clr();
        strt_log.delete();
        nxt_log.delete();
        ovr_cnt = 0; ovr_bad = 0; done_cnt = 0; upd_cnt = 0; upd_bad = 0;
        strt_time = -1; to_time = -1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; trig = 1'b0;
        tick(2);
        rst = 1'b0;
        clr();
    endtask

    function automatic logic [8:0] seq3(input int s);
        if (strt_log.size() < s + 3) return 9'h1ff;
        return {strt_log[s], strt_log[s+1], strt_log[s+2]};
    endfunction

    function automatic logic [50:0] all_outs();
        return {strt_cnv, chnnl, ch_data, ch_vld, upd, sweep_done, nxt, ovrrun, batt_low, timeout_err};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        res_tab[0] = 12'h111; res_tab[1] = 12'h222; res_tab[2] = 12'h933;
        tick(3);
        check("reset_outputs", 64'(all_outs()), 64'd0);

        // Periodic sweeps back to back: period 9, latency 2, all channels
        do_reset();
        period = 19'd9; mode = 1'b0; ch_mask = 3'b111; lat = 2; en = 1'b1;
        tick(35);
        check("t1_nxt_spacing", 64'(nxt_log.size() >= 2 ? nxt_log[1] - nxt_log[0] : -1), 64'd10);
        check("t1_seq_a", 64'(seq3(0)), 64'({3'd0, 3'd1, 3'd2}));
        check("t1_seq_b", 64'(seq3(3)), 64'({3'd0, 3'd1, 3'd2}));
        check("t1_done_cnt", 64'(done_cnt), 64'd2);
        check("t1_ovrrun", 64'(ovr_cnt), 64'd0);
        check("t1_upd_cnt", 64'(upd_cnt), 64'd7);
        check("t1_upd_onehot", 64'(upd_bad), 64'd0);
        en = 1'b0;
        tick(10);
        check("t1_data", 64'(ch_data), 64'({12'h933, 12'h222, 12'h111}));
        check("t1_vld", 64'(ch_vld), 64'd7);
        check("t1_batt", 64'(batt_low), 64'd0);

        // Sparse mask and battery threshold
        do_reset();
        res_tab[0] = 12'h123; res_tab[1] = 12'hAAA; res_tab[2] = 12'h7FF;
        ch_mask = 3'b101; en = 1'b1;
        tick(19);
        en = 1'b0;
        tick(2);
        check("t2_ch0", 64'(ch_data[11:0]), 64'h123);
        check("t2_ch1", 64'(ch_data[23:12]), 64'h000);
        check("t2_ch2", 64'(ch_data[35:24]), 64'h7FF);
        check("t2_vld", 64'(ch_vld), 64'b101);
        check("t2_launches", 64'(strt_log.size()), 64'd2);
        check("t2_seq", 64'(strt_log.size() == 2 ? {strt_log[0], strt_log[1]} : 6'h3f), 64'({3'd0, 3'd2}));
        check("t2_batt_low", 64'(batt_low), 64'd1);
        res_tab[2] = 12'h800;
        en = 1'b1;
        tick(19);
        en = 1'b0;
        tick(2);
        check("t2_batt_th", 64'(batt_low), 64'd0);
        check("t2_ch2_b", 64'(ch_data[35:24]), 64'h800);
        check("t2_done_cnt", 64'(done_cnt), 64'd2);

        // Overrun: period 2, latency 20
        do_reset();
        res_tab[0] = 12'h111; res_tab[1] = 12'h222; res_tab[2] = 12'h933;
        period = 19'd2; ch_mask = 3'b111; lat = 20; en = 1'b1;
        tick(68);
        en = 1'b0;
        check("t3_ovr_cnt", 64'(ovr_cnt), 64'd21);
        check("t3_ovr_on_nxt", 64'(ovr_bad), 64'd0);
        check("t3_seq", 64'(seq3(0)), 64'({3'd0, 3'd1, 3'd2}));
        check("t3_launches", 64'(strt_log.size()), 64'd3);
        check("t3_done_cnt", 64'(done_cnt), 64'd1);
        tick(5);

        // Timeout on trigger, then recovery
        do_reset();
        period = 19'd9; mode = 1'b1; ch_mask = 3'b111; a2d_on = 1'b0; en = 1'b1;
        tick(2);
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        for (int i = 0; i < 1100 && !timeout_err; i++) tick(1);
        tick(1);
        check("t4_timeout_set", 64'(timeout_err), 64'd1);
        check("t4_to_delay", 64'(to_time - strt_time), 64'd1024);
        check("t4_launches", 64'(strt_log.size()), 64'd1);
        check("t4_no_done", 64'(done_cnt), 64'd0);
        check("t4_no_vld", 64'(ch_vld), 64'd0);
        a2d_on = 1'b1; lat = 3;
        clr();
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        tick(20);
        check("t4_relaunch", 64'(seq3(0)), 64'({3'd0, 3'd1, 3'd2}));
        check("t4_redone", 64'(done_cnt), 64'd1);
        check("t4_sticky", 64'(timeout_err), 64'd1);
        check("t4_vld", 64'(ch_vld), 64'd7);

        // Enable dropped during ch1 conversion
        do_reset();
        mode = 1'b0; period = 19'd9; ch_mask = 3'b111; lat = 4;
        res_tab[1] = 12'h5A5; en = 1'b1;
        tick(17);
        en = 1'b0;
        tick(15);
        check("t5_vld", 64'(ch_vld), 64'b011);
        check("t5_ch1", 64'(ch_data[23:12]), 64'h5A5);
        check("t5_launches", 64'(strt_log.size()), 64'd2);
        check("t5_no_done", 64'(done_cnt), 64'd0);
        check("t5_nxt_held", 64'(nxt_log.size()), 64'd1);
        clr();
        en = 1'b1;
        tick(9);
        check("t5_cnt_zero_a", 64'(nxt_log.size()), 64'd0);
        tick(1);
        check("t5_cnt_zero_b", 64'(nxt_log.size()), 64'd1);
        en = 1'b0;
        tick(20);

        // Empty mask, then reset mid-conversion with a stray completion afterwards
        do_reset();
        period = 19'd100; mode = 1'b1; ch_mask = 3'b000; en = 1'b1;
        tick(2);
        clr();
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        check("t6_done_now", 64'(sweep_done), 64'd1);
        check("t6_no_strt", 64'(strt_cnv), 64'd0);
        tick(1);
        check("t6_done_pulse", 64'(sweep_done), 64'd0);
        tick(3);
        check("t6_no_launch", 64'(strt_log.size()), 64'd0);
        ch_mask = 3'b111; lat = 10;
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        check("t6_rst_outputs", 64'(all_outs()), 64'd0);
        rst = 1'b0;
        clr();
        tick(15);
        check("t6_stray_vld", 64'(ch_vld), 64'd0);
        check("t6_stray_upd", 64'(upd_cnt), 64'd0);
        check("t6_stray_strt", 64'(strt_log.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
